// File: rtl/ddr4_axi_arbiter_pkg.sv
// Shared definitions for the DDR4 AXI arbiter: FSM state encoding and a width helper.
package ddr4_arb_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    WAIT_B = 2'd2,
    WAIT_R = 2'd3
  } arb_state_e;

  // Ceiling log2 with a floor of 1 so single-bit indices stay legal.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/ddr4_axi_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after the pointer, with wrap.
module rr_pick
  import ddr4_arb_defs::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]        req_i,
  input  logic [clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]        gnt_o,
  output logic [clog2(NREQ)-1:0] idx_o
);

  localparam int IW = clog2(NREQ);

  // Lowest index at or below the pointer is the wrap fallback; any hit above the pointer overrides it.
  always_comb begin
    idx_o = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req_i[i] && (IW'(i) <= ptr_i)) idx_o = IW'(i);
    for (int i = NREQ - 1; i >= 0; i--)
      if (req_i[i] && (IW'(i) > ptr_i)) idx_o = IW'(i);
  end

  assign gnt_o = (|req_i) ? (NREQ'(1) << idx_o) : '0;

endmodule

// File: rtl/ddr4_axi_arbiter.sv
// Round-robin arbiter with per-grant quota in front of the PS DDR4 AXI slave port,
// holding each grant until the shared port completes, plus a completion watchdog.
module ddr4_axi_arbiter
  import ddr4_arb_defs::*;
#(
  parameter int NREQ        = 4,
  parameter int QUOTA       = 4,
  parameter int TIMEOUT_CYC = 4096,
  parameter int TO_W        = 16
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic [NREQ-1:0]        REQ,
  input  logic [NREQ-1:0]        REQ_WRITE,
  output logic [NREQ-1:0]        GNT,
  output logic                   GNT_VALID,
  output logic [clog2(NREQ)-1:0] GNT_IDX,
  input  logic                   M_AWVALID,
  input  logic                   M_AWREADY,
  input  logic                   M_ARVALID,
  input  logic                   M_ARREADY,
  input  logic                   M_BVALID,
  input  logic                   M_BREADY,
  input  logic                   M_RVALID,
  input  logic                   M_RREADY,
  input  logic                   M_RLAST,
  input  logic                   ERR_CLR,
  output logic                   ERR_TIMEOUT,
  output logic [clog2(NREQ)-1:0] ERR_IDX
);

  localparam int IW = clog2(NREQ);
  localparam int QW = clog2(QUOTA + 1);

  arb_state_e      state_q;
  logic [NREQ-1:0] gnt_q;
  logic            gvld_q;
  logic [IW-1:0]   idx_q;
  logic            dir_q;
  logic [IW-1:0]   ptr_q;
  logic [QW-1:0]   cnt_q;
  logic [TO_W-1:0] wd_q;
  logic            err_q;
  logic [IW-1:0]   eidx_q;

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            aw_hs, ar_hs, in_wait, done, wd_run, expire;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i (REQ),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  assign aw_hs   = M_AWVALID & M_AWREADY;
  assign ar_hs   = M_ARVALID & M_ARREADY;
  assign in_wait = (state_q == WAIT_B) || (state_q == WAIT_R);
  assign done    = (state_q == WAIT_B) ? (M_BVALID & M_BREADY)
                                       : (M_RVALID & M_RREADY & M_RLAST);
  // Counter saturates at TIMEOUT_CYC; expiry is the single step from TIMEOUT_CYC-1.
  assign wd_run  = (TIMEOUT_CYC != 0) && (wd_q != TO_W'(TIMEOUT_CYC));
  assign expire  = (TIMEOUT_CYC != 0) && in_wait && (wd_q == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      gvld_q  <= 1'b0;
      idx_q   <= '0;
      dir_q   <= 1'b0;
      ptr_q   <= IW'(NREQ - 1);
      cnt_q   <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      eidx_q  <= '0;
    end else begin
      if (expire) begin
        err_q  <= 1'b1;
        eidx_q <= idx_q;
      end else if (ERR_CLR) begin
        err_q  <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (|REQ) begin
            state_q <= ADDR;
            gnt_q   <= pick_gnt;
            gvld_q  <= 1'b1;
            idx_q   <= pick_idx;
            dir_q   <= REQ_WRITE[pick_idx];
          end
        end
        ADDR: begin
          if (dir_q && aw_hs) begin
            state_q <= WAIT_B;
            wd_q    <= '0;
          end else if (!dir_q && ar_hs) begin
            state_q <= WAIT_R;
            wd_q    <= '0;
          end else if (!REQ[idx_q]) begin
            // Abandoned request: release without advancing the round-robin pointer.
            state_q <= IDLE;
            gnt_q   <= '0;
            gvld_q  <= 1'b0;
            cnt_q   <= '0;
          end
        end
        WAIT_B, WAIT_R: begin
          if (wd_run) wd_q <= wd_q + TO_W'(1);
          if (done) begin
            if (REQ[idx_q] && (cnt_q < QW'(QUOTA - 1))) begin
              state_q <= ADDR;
              cnt_q   <= cnt_q + QW'(1);
              dir_q   <= REQ_WRITE[idx_q];
            end else begin
              state_q <= IDLE;
              ptr_q   <= idx_q;
              cnt_q   <= '0;
              gnt_q   <= '0;
              gvld_q  <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign GNT         = gnt_q;
  assign GNT_VALID   = gvld_q;
  assign GNT_IDX     = idx_q;
  assign ERR_TIMEOUT = err_q;
  assign ERR_IDX     = eidx_q;

endmodule

// File: tb/tb_ddr4_axi_arbiter.sv
// Scoreboard bench for ddr4_axi_arbiter: directed AXI-observation stimulus, grant/error monitor.
module tb_ddr4_axi_arbiter;

  localparam int NREQ = 4;

  logic            ACLK = 1'b0;
  logic            ARESETN = 1'b0;
  logic [NREQ-1:0] REQ = '0, REQ_WRITE = '0;
  logic [NREQ-1:0] GNT;
  logic            GNT_VALID;
  logic [1:0]      GNT_IDX, ERR_IDX;
  logic            M_AWVALID = 0, M_AWREADY = 0, M_ARVALID = 0, M_ARREADY = 0;
  logic            M_BVALID = 0, M_BREADY = 0, M_RVALID = 0, M_RREADY = 0, M_RLAST = 0;
  logic            ERR_CLR = 0;
  logic            ERR_TIMEOUT;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_gnt_q[$];
  int exp_err_q[$];

  ddr4_axi_arbiter #(.NREQ(NREQ), .QUOTA(4), .TIMEOUT_CYC(16), .TO_W(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .REQ(REQ), .REQ_WRITE(REQ_WRITE),
    .GNT(GNT), .GNT_VALID(GNT_VALID), .GNT_IDX(GNT_IDX),
    .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_BVALID(M_BVALID), .M_BREADY(M_BREADY), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
    .M_RLAST(M_RLAST), .ERR_CLR(ERR_CLR), .ERR_TIMEOUT(ERR_TIMEOUT), .ERR_IDX(ERR_IDX)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge ACLK);
  endtask

  task automatic wait_gnt(input string name, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!GNT_VALID && cyc < 20);
    if (!GNT_VALID) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic addr_hs(input bit wr, input int k, input bit drop);
    if (wr) begin M_AWVALID = 1; M_AWREADY = 1; end
    else    begin M_ARVALID = 1; M_ARREADY = 1; end
    tick();
    M_AWVALID = 0; M_AWREADY = 0; M_ARVALID = 0; M_ARREADY = 0;
    if (drop) REQ[k] = 1'b0;
  endtask

  task automatic complete(input bit wr, input int beats);
    if (wr) begin
      M_BVALID = 1; M_BREADY = 1;
      tick();
      M_BVALID = 0; M_BREADY = 0;
    end else begin
      for (int b = 0; b < beats; b++) begin
        M_RVALID = 1; M_RREADY = 1; M_RLAST = (b == beats - 1);
        tick();
      end
      M_RVALID = 0; M_RREADY = 0; M_RLAST = 0;
    end
  endtask

  // Monitor: every new grant and every new watchdog flag is matched against the scoreboard.
  initial begin : monitor
    logic pv, pe;
    int   e;
    pv = 0; pe = 0;
    forever begin
      @(negedge ACLK);
      if (GNT_VALID && !pv) begin
        if (exp_gnt_q.size() == 0) check("mon_gnt_unexpected", int'(GNT_IDX), -1);
        else begin
          e = exp_gnt_q.pop_front();
          check("mon_gnt_idx", int'(GNT_IDX), e);
          check("mon_gnt_onehot", int'(GNT), 1 << e);
        end
      end
      if (ERR_TIMEOUT && !pe) begin
        if (exp_err_q.size() == 0) check("mon_err_unexpected", int'(ERR_IDX), -1);
        else begin
          e = exp_err_q.pop_front();
          check("mon_err_idx", int'(ERR_IDX), e);
        end
      end
      pv = GNT_VALID;
      pe = ERR_TIMEOUT;
    end
  end

  initial begin : guard
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int cyc;
    int k;
    int order[5];
    order = '{1, 2, 3, 0, 1};

    // Reset values
    tick(2);
    check("rst_gnt", int'(GNT), 0);
    check("rst_gnt_valid", int'(GNT_VALID), 0);
    check("rst_gnt_idx", int'(GNT_IDX), 0);
    check("rst_err", int'(ERR_TIMEOUT), 0);
    check("rst_err_idx", int'(ERR_IDX), 0);
    ARESETN = 1'b1;
    tick();

    // Single master 0 write; pointer starts at 3 so master 0 wins
    exp_gnt_q.push_back(0);
    REQ = 4'b0001; REQ_WRITE = 4'b0001;
    tick();
    check("t1_gnt_next_cycle", int'(GNT), 1);
    addr_hs(1, 0, 1);
    check("t1_hold_wait_b", int'(GNT), 1);
    complete(1, 1);
    check("t1_release_gnt", int'(GNT), 0);
    check("t1_release_valid", int'(GNT_VALID), 0);

    // Master 1 (read) abandons in ADDR; a stray AW must not be taken
    exp_gnt_q.push_back(1);
    REQ = 4'b0011; REQ_WRITE = 4'b0000;
    tick();
    check("t5_gnt", int'(GNT), 2);
    M_AWVALID = 1; M_AWREADY = 1;
    tick();
    M_AWVALID = 0; M_AWREADY = 0;
    check("t5_aw_ignored_hold", int'(GNT), 2);
    REQ = 4'b0000;
    tick();
    check("t5_drop_gnt", int'(GNT), 0);
    check("t5_drop_valid", int'(GNT_VALID), 0);
    exp_gnt_q.push_back(1);
    REQ = 4'b0011;
    tick();
    check("t5_ptr_kept", int'(GNT_IDX), 1);
    REQ = 4'b0000;
    tick();
    check("t5_drop2_gnt", int'(GNT), 0);

    // All masters requesting, one transaction each: order 1,2,3,0,1 with a gap
    REQ = 4'b1111; REQ_WRITE = 4'b1010;
    for (int r = 0; r < 5; r++) begin
      k = order[r];
      exp_gnt_q.push_back(k);
      wait_gnt("t2_wait", cyc);
      check("t2_gap_len", cyc, 1);
      addr_hs(REQ_WRITE[k], k, 1);
      complete(REQ_WRITE[k], 2);
      check("t2_gap", int'(GNT_VALID), 0);
      if (r < 4) REQ[k] = 1'b1;
      else REQ = 4'b0000;
    end

    // Master 2 alone, six read bursts: four under the first grant, two under the next
    REQ = 4'b0100; REQ_WRITE = 4'b0000;
    exp_gnt_q.push_back(2);
    wait_gnt("t3_wait", cyc);
    for (int b = 0; b < 6; b++) begin
      addr_hs(0, 2, (b == 5));
      if (b == 0) begin
        M_RVALID = 1; M_RLAST = 1;
        tick();
        M_RVALID = 0; M_RLAST = 0;
        check("t3_no_rready_hold", int'(GNT), 4);
      end
      complete(0, 3);
      if (b == 3) begin
        check("t3_quota_gap", int'(GNT_VALID), 0);
        exp_gnt_q.push_back(2);
        wait_gnt("t3_rewait", cyc);
        check("t3_regrant_len", cyc, 1);
      end else if (b == 5) begin
        check("t3_final_release", int'(GNT), 0);
      end else begin
        check("t3_grant_kept", int'(GNT), 4);
      end
    end

    // Watchdog on master 3 read: flag after 16 cycles, RLAST at cycle 40
    REQ = 4'b1000; REQ_WRITE = 4'b0000;
    exp_gnt_q.push_back(3);
    exp_err_q.push_back(3);
    wait_gnt("t4_wait", cyc);
    addr_hs(0, 3, 1);
    tick(15);
    check("t4_err_before", int'(ERR_TIMEOUT), 0);
    tick();
    check("t4_err_set", int'(ERR_TIMEOUT), 1);
    check("t4_err_idx", int'(ERR_IDX), 3);
    check("t4_gnt_held", int'(GNT), 8);
    tick(23);
    M_RVALID = 1; M_RREADY = 1; M_RLAST = 1;
    tick();
    M_RVALID = 0; M_RREADY = 0; M_RLAST = 0;
    check("t4_release", int'(GNT), 0);
    check("t4_err_sticky", int'(ERR_TIMEOUT), 1);
    ERR_CLR = 1;
    tick();
    ERR_CLR = 0;
    check("t4_err_clr", int'(ERR_TIMEOUT), 0);

    // Clear and expiry in the same cycle: set wins
    REQ = 4'b0001; REQ_WRITE = 4'b0001;
    exp_gnt_q.push_back(0);
    exp_err_q.push_back(0);
    wait_gnt("t4b_wait", cyc);
    addr_hs(1, 0, 1);
    tick(15);
    ERR_CLR = 1;
    tick();
    ERR_CLR = 0;
    check("t4b_set_wins", int'(ERR_TIMEOUT), 1);
    check("t4b_err_idx", int'(ERR_IDX), 0);
    complete(1, 1);
    check("t4b_release", int'(GNT), 0);

    // Asynchronous reset in WAIT_R, then a fresh grant
    REQ = 4'b0010; REQ_WRITE = 4'b0000;
    exp_gnt_q.push_back(1);
    wait_gnt("t6_wait", cyc);
    addr_hs(0, 1, 1);
    M_RVALID = 1; M_RREADY = 1;
    tick();
    #2 ARESETN = 1'b0;
    #1;
    check("t6_rst_gnt", int'(GNT), 0);
    check("t6_rst_valid", int'(GNT_VALID), 0);
    check("t6_rst_idx", int'(GNT_IDX), 0);
    check("t6_rst_err", int'(ERR_TIMEOUT), 0);
    check("t6_rst_err_idx", int'(ERR_IDX), 0);
    M_RVALID = 0; M_RREADY = 0;
    tick();
    ARESETN = 1'b1;
    REQ = 4'b0100;
    exp_gnt_q.push_back(2);
    tick();
    check("t6_gnt_after_reset", int'(GNT), 4);
    REQ = 4'b0000;
    tick(3);

    check("sb_gnt_drained", exp_gnt_q.size(), 0);
    check("sb_err_drained", exp_err_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
